// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel edge detector: FSM state, kernel weights
// and the magnitude width derivation.
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    // Sobel kernel is 1-2-1 smoothing across the derivative; the centre weight of 2 is a shift.
    localparam int K_CENTRE_SHIFT = 1;

    // |Gx|+|Gy| peaks at 8*(2^pix_w-1), so three extra bits hold it without overflow.
    function automatic int mag_width(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: circular RAM addressed by column, combinational read of the
// old contents in the same cycle the new pixel is written (read-before-write).
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one edge bit per pixel out, with
// valid/ready on both sides. Define SOBEL_MAG_OUT_EN to add the registered out_mag port.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int PIX_W  = 8,
    localparam int MAG_W = mag_width(PIX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] threshold,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_edge,
`ifdef SOBEL_MAG_OUT_EN
    output logic [MAG_W-1:0] out_mag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);

    localparam int G_W = PIX_W + 3;
    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    state_t state, state_next;
    logic [XW-1:0] in_x, out_x;
    logic [YW-1:0] in_y, out_y;
    logic out_free, accept, load;
    logic in_last, fill_done, out_last, out_last_q;
    logic border, edge_bit;
    logic [MAG_W-1:0] thr_q, mag;
    logic signed [G_W-1:0] gx, gy;
    logic [PIX_W-1:0] row1, row2;
    logic [PIX_W-1:0] t0, t1, m0, m1, b0, b1;

    function automatic logic signed [G_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic signed [G_W-1:0] smooth(input logic [PIX_W-1:0] a, b, c);
        return ext(a) + (ext(b) <<< K_CENTRE_SHIFT) + ext(c);
    endfunction

    function automatic logic [MAG_W-1:0] abs_sum(input logic signed [G_W-1:0] x, y);
        logic [MAG_W-1:0] ax, ay;
        ax = x[G_W-1] ? $unsigned(-x) : $unsigned(x);
        ay = y[G_W-1] ? $unsigned(-y) : $unsigned(y);
        return ax + ay;
    endfunction

    assign out_free   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign in_last    = (in_x == X_LAST) && (in_y == Y_LAST);
    assign fill_done  = (in_x == '0) && (in_y == YW'(1));
    assign out_last   = (out_x == X_LAST) && (out_y == Y_LAST);
    assign frame_done = out_valid && out_ready && out_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && fill_done) state_next = RUN;
            RUN:     if (accept && in_last)   state_next = FLUSH;
            FLUSH:   if (load && out_last)    state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        load     = 1'b0;
        case (state)
            FILL:  in_ready = out_free;
            RUN: begin
                in_ready = out_free;
                load     = in_valid && out_free;
            end
            FLUSH: load = out_free;
            default: ;
        endcase
    end

    // Stage p0: window columns 0/1 are registered, column 2 is the live pixel plus line-buffer reads
    sobel_line_buffer #(.DATA_W(PIX_W), .DEPTH(WIDTH)) u_lb_prev (
        .clk(clk), .wr_en(accept), .addr(in_x), .wr_data(in_pixel), .rd_data(row1)
    );
    sobel_line_buffer #(.DATA_W(PIX_W), .DEPTH(WIDTH)) u_lb_prev2 (
        .clk(clk), .wr_en(accept), .addr(in_x), .wr_data(row1), .rd_data(row2)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            t0 <= t1;  t1 <= row2;
            m0 <= m1;  m1 <= row1;
            b0 <= b1;  b1 <= in_pixel;
            if (in_x == '0 && in_y == '0) thr_q <= threshold;
        end
    end

    // Window edges of the frame hold wrapped or stale pixels; masking the border hides them.
    assign border   = (out_x == '0) || (out_x == X_LAST) || (out_y == '0) || (out_y == Y_LAST)
                      || (state == FLUSH);
    assign gx       = smooth(row2, row1, in_pixel) - smooth(t0, m0, b0);
    assign gy       = smooth(b0, b1, in_pixel) - smooth(t0, t1, row2);
    assign mag      = border ? '0 : abs_sum(gx, gy);
    assign edge_bit = mag > thr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_x  <= '0;
            in_y  <= '0;
            out_x <= '0;
            out_y <= '0;
        end else begin
            if (accept) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= in_last ? '0 : in_y + 1'b1;
                end else begin
                    in_x <= in_x + 1'b1;
                end
            end
            if (load) begin
                if (out_x == X_LAST) begin
                    out_x <= '0;
                    out_y <= out_last ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
        end
    end

    // Stage p1: output register, replaced in place when a handshake and a load coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_edge   <= 1'b0;
            out_last_q <= 1'b0;
`ifdef SOBEL_MAG_OUT_EN
            out_mag    <= '0;
`endif
        end else if (load) begin
            out_valid  <= 1'b1;
            out_edge   <= edge_bit;
            out_last_q <= out_last;
`ifdef SOBEL_MAG_OUT_EN
            out_mag    <= mag;
`endif
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: directed frames checked against a frame-level Sobel model.
module tb_sobel_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
    localparam int MW = PW + 3;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] threshold = '0;
    logic [PW-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_edge;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          frame_done;
`ifdef SOBEL_MAG_OUT_EN
    logic [MW-1:0] out_mag;
`endif

    always #5 clk = ~clk;

    sobel_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .threshold(threshold),
        .in_pixel(in_pixel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_edge(out_edge),
`ifdef SOBEL_MAG_OUT_EN
        .out_mag(out_mag),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic          e;
        logic [MW-1:0] m;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   img [H][W];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   out_cnt = 0, fd_cnt = 0, edge_cnt = 0, acc_cnt = 0;
    bit   rand_in = 0, rand_out = 0, ignore_out = 1, lat_chk = 0, seen_valid = 0, timed_out = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sobel magnitude straight from the image; border centres are forced to zero.
    function automatic int calc_mag(input int y, input int x);
        int gx, gy;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = (img[y-1][x+1] + 2 * img[y][x+1] + img[y+1][x+1])
           - (img[y-1][x-1] + 2 * img[y][x-1] + img[y+1][x-1]);
        gy = (img[y+1][x-1] + 2 * img[y+1][x] + img[y+1][x+1])
           - (img[y-1][x-1] + 2 * img[y-1][x] + img[y-1][x+1]);
        return iabs(gx) + iabs(gy);
    endfunction

    function automatic int model_edges(input int thr);
        int cnt = 0;
        for (int j = 0; j < N; j++) if (calc_mag(j / W, j % W) > thr) cnt++;
        return cnt;
    endfunction

    task automatic model_frame(input int thr);
        exp_t ex;
        for (int j = 0; j < N; j++) begin
            int m;
            m       = calc_mag(j / W, j % W);
            ex.e    = (m > thr);
            ex.m    = MW'(m);
            ex.last = (j == N - 1);
            exp_q.push_back(ex);
        end
    endtask

    task automatic set_img(input int kind);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (kind == 0) ? 77 : (kind == 1) ? ((x >= 4) ? 100 : 0)
                                                           : int'($urandom_range(0, 255));
    endtask

    task automatic push(input int p);
        int guard = 0;
        if (timed_out) return;
        while (rand_in && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pixel = PW'(p);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL in_ready_timeout: got 0 for %0d cycles, expected 1", guard);
                timed_out = 1;
                in_valid  = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_frame(input int thr0, input int thr_mid);
        if (timed_out) return;
        threshold = MW'(thr0);
        model_frame(thr0);
        for (int j = 0; j < N; j++) begin
            if (j == 20 && thr_mid >= 0) threshold = MW'(thr_mid);
            push(img[j / W][j % W]);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d outputs pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        out_cnt    = 0;
        fd_cnt     = 0;
        edge_cnt   = 0;
        acc_cnt    = 0;
        seen_valid = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_out ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Compare process: every negedge, a pending handshake is checked against the model queue.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (lat_chk && out_valid && !seen_valid) begin
                    seen_valid = 1;
                    check("latency_accepts", acc_cnt, W + 2);
                end
                if (in_valid && in_ready) acc_cnt++;
                if (!ignore_out) begin
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL extra_output: got output %0d, expected none", out_cnt);
                        end else begin
                            ex = exp_q.pop_front();
                            check($sformatf("edge[%0d]", out_cnt), out_edge, ex.e);
`ifdef SOBEL_MAG_OUT_EN
                            check($sformatf("mag[%0d]", out_cnt), out_mag, ex.m);
`endif
                            check($sformatf("frame_done[%0d]", out_cnt), frame_done, ex.last);
                        end
                        out_cnt++;
                        if (out_edge) edge_cnt++;
                        if (frame_done) fd_cnt++;
                    end else begin
                        check("frame_done_idle", frame_done, 0);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_edge", out_edge, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef SOBEL_MAG_OUT_EN
        check("rst_out_mag", out_mag, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        ignore_out = 0;

        set_img(1);
        check("model_mag_step_x3", calc_mag(1, 3), 400);
        check("model_mag_step_x4", calc_mag(4, 4), 400);
        check("model_mag_step_x2", calc_mag(2, 2), 0);
        check("model_mag_border", calc_mag(0, 3), 0);
        check("model_step_edges_399", model_edges(399), 8);
        check("model_step_edges_400", model_edges(400), 0);

        // Flat frame, threshold 0, unstalled, with first-output latency
        start_test();
        set_img(0);
        lat_chk = 1;
        send_frame(0, -1);
        drain();
        lat_chk = 0;
        check("flat_outputs", out_cnt, N);
        check("flat_frame_done", fd_cnt, 1);
        check("flat_edges", edge_cnt, 0);

        // Vertical step, threshold 399 then 400
        start_test();
        set_img(1);
        send_frame(399, -1);
        drain();
        check("step399_outputs", out_cnt, N);
        check("step399_edges", edge_cnt, 8);

        start_test();
        send_frame(400, -1);
        drain();
        check("step400_outputs", out_cnt, N);
        check("step400_edges", edge_cnt, 0);

        // Step frame under random input gaps and output backpressure
        start_test();
        rand_in  = 1;
        rand_out = 1;
        send_frame(399, -1);
        drain();
        check("stall_outputs", out_cnt, N);
        check("stall_edges", edge_cnt, 8);
        check("stall_frame_done", fd_cnt, 1);

        // Random image exercising both gradients, still stalled
        start_test();
        set_img(2);
        send_frame(300, -1);
        drain();
        check("random_outputs", out_cnt, N);
        check("random_edges", edge_cnt, model_edges(300));
        rand_in  = 0;
        rand_out = 0;
        @(posedge clk); #1;

        // Reset after 20 accepts, then a full flat frame
        start_test();
        ignore_out = 1;
        set_img(0);
        for (int j = 0; j < 20; j++) push(77);
        rst = 1'b1;
        #1;
        check("midrst_out_valid_now", out_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_out_valid", out_valid, 0);
            check("midrst_in_ready", in_ready, 1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ignore_out = 0;
        send_frame(0, -1);
        drain();
        check("midrst_outputs", out_cnt, N);
        check("midrst_frame_done", fd_cnt, 1);

        // Back-to-back step frames, threshold raised mid-frame-1
        start_test();
        set_img(1);
        send_frame(399, 400);
        send_frame(400, -1);
        drain();
        check("b2b_outputs", out_cnt, 2 * N);
        check("b2b_frame_done", fd_cnt, 2);
        check("b2b_edges", edge_cnt, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
